// File: rtl/pwc_hist_pipe_if.sv
// Bundles the PWC history store's data inputs, control strobes and tap outputs.
// The master drives samples and controls; the slave (the history store) returns taps.
interface pwc_hist_pipe_if #(
    parameter int NUM_UI = 8,
    parameter int VAL_W  = 16,
    parameter int TIME_W = 16,
    parameter int CNT_W  = $clog2(NUM_UI + 1)
);
    logic signed [VAL_W-1:0]  in;
    logic                     time_eq_in;
    logic [TIME_W-1:0]        time_next;
    logic                     freeze;
    logic                     flush;

    logic signed [VAL_W-1:0]  value_hist [NUM_UI];
    logic [TIME_W-1:0]        time_hist  [NUM_UI];
    logic [TIME_W-1:0]        age        [NUM_UI];
    logic [NUM_UI-1:0]        tap_valid;
    logic [CNT_W-1:0]         fill_cnt;
    logic                     hist_upd;

    modport master (
        output in, time_eq_in, time_next, freeze, flush,
        input  value_hist, time_hist, age, tap_valid, fill_cnt, hist_upd
    );

    modport slave (
        input  in, time_eq_in, time_next, freeze, flush,
        output value_hist, time_hist, age, tap_valid, fill_cnt, hist_upd
    );
endinterface

// File: rtl/pwc_hist_pipe.sv
// Coherent (timestamp, value) shift history for the PWC path, with per-tap valid,
// fill count and registered per-tap age. The value chain trails the time chain by one cycle.
module pwc_hist_pipe #(
    parameter int NUM_UI = 8,
    parameter int VAL_W  = 16,
    parameter int TIME_W = 16,
    parameter int CNT_W  = $clog2(NUM_UI + 1)
) (
    input  logic              clk_sys,
    input  logic              rst,
    pwc_hist_pipe_if.slave    bus
);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(NUM_UI);

    logic signed [VAL_W-1:0] value_q [NUM_UI];
    logic signed [VAL_W-1:0] value_d [NUM_UI];
    logic [TIME_W-1:0]       time_q  [NUM_UI];
    logic [TIME_W-1:0]       time_d  [NUM_UI];
    logic [TIME_W-1:0]       age_q   [NUM_UI];
    logic [TIME_W-1:0]       age_d   [NUM_UI];
    logic [NUM_UI-1:0]       tap_valid_q, tap_valid_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic                    upd_q, upd_d;
    logic                    pending_q, pending_d;
    logic                    accept;

    assign accept = bus.time_eq_in & ~bus.freeze & ~bus.flush & ~rst;

    always_comb begin
        value_d     = value_q;
        time_d      = time_q;
        tap_valid_d = tap_valid_q;
        fill_d      = fill_q;
        upd_d       = 1'b0;
        pending_d   = accept;

        if (accept) begin
            time_d[0] = bus.time_next;
            for (int k = 1; k < NUM_UI; k++) begin
                time_d[k] = time_q[k-1];
            end
        end

        // Value data always completes its shift; only the bookkeeping yields to flush.
        if (pending_q) begin
            value_d[0] = bus.in;
            for (int k = 1; k < NUM_UI; k++) begin
                value_d[k] = value_q[k-1];
            end
            if (!bus.flush) begin
                tap_valid_d = {tap_valid_q[NUM_UI-2:0], 1'b1};
                fill_d      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
                upd_d       = 1'b1;
            end
        end

        if (bus.flush) begin
            tap_valid_d = '0;
            fill_d      = '0;
        end
    end

    // Modular subtract handles wrap of time_next past the stamp.
    generate
        for (genvar gi = 0; gi < NUM_UI; gi++) begin : g_tap
            assign age_d[gi]          = tap_valid_q[gi] ? (bus.time_next - time_q[gi]) : '0;
            assign bus.value_hist[gi] = value_q[gi];
            assign bus.time_hist[gi]  = time_q[gi];
            assign bus.age[gi]        = age_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int k = 0; k < NUM_UI; k++) begin
                value_q[k] <= '0;
                time_q[k]  <= '0;
                age_q[k]   <= '0;
            end
            tap_valid_q <= '0;
            fill_q      <= '0;
            upd_q       <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            value_q     <= value_d;
            time_q      <= time_d;
            age_q       <= age_d;
            tap_valid_q <= tap_valid_d;
            fill_q      <= fill_d;
            upd_q       <= upd_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.tap_valid = tap_valid_q;
    assign bus.fill_cnt  = fill_q;
    assign bus.hist_upd  = upd_q;
endmodule

// File: tb/tb_pwc_hist_pipe.sv
// Randomised and directed stimulus for pwc_hist_pipe, checked every cycle against a
// queue-based reference of the history contents.
module tb_pwc_hist_pipe;
    localparam int N  = 8;
    localparam int VW = 16;
    localparam int TW = 16;
    localparam int CW = $clog2(N + 1);

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;

    pwc_hist_pipe_if #(.NUM_UI(N), .VAL_W(VW), .TIME_W(TW), .CNT_W(CW)) bus ();

    pwc_hist_pipe #(.NUM_UI(N), .VAL_W(VW), .TIME_W(TW), .CNT_W(CW)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: newest-first queues of stamps/values, count of valid taps.
    logic [TW-1:0]        m_time [$];
    logic signed [VW-1:0] m_val  [$];
    logic [TW-1:0]        m_age  [N];
    int                   m_fill;
    bit                   m_upd;
    bit                   m_due;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        m_time.delete();
        m_val.delete();
        for (int k = 0; k < N; k++) begin
            m_time.push_back('0);
            m_val.push_back('0);
            m_age[k] = '0;
        end
        m_fill = 0;
        m_upd  = 0;
        m_due  = 0;
    endtask

    task automatic model_edge(input bit ev, input logic [TW-1:0] tn, input logic signed [VW-1:0] v,
                              input bit fz, input bit fl, input bit r);
        logic [TW-1:0] new_age [N];
        bit acc;
        for (int k = 0; k < N; k++) new_age[k] = (k < m_fill) ? tn - m_time[k] : '0;
        if (r) begin
            model_clear();
        end else begin
            acc = ev && !fz && !fl;
            m_upd = 0;
            if (m_due) begin
                m_val.push_front(v);
                void'(m_val.pop_back());
                if (!fl) begin
                    m_fill = (m_fill < N) ? m_fill + 1 : N;
                    m_upd  = 1;
                end
            end
            if (fl) m_fill = 0;
            if (acc) begin
                m_time.push_front(tn);
                void'(m_time.pop_back());
            end
            m_due = acc;
            m_age = new_age;
        end
    endtask

    task automatic compare_all();
        logic [N:0] mask;
        mask = (9'd1 << m_fill) - 9'd1;
        check_eq("fill_cnt",  64'(bus.fill_cnt), 64'(m_fill));
        check_eq("tap_valid", 64'(bus.tap_valid), 64'(mask[N-1:0]));
        check_eq("hist_upd",  64'(bus.hist_upd), 64'(m_upd));
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("time_hist[%0d]", k),  64'(bus.time_hist[k]),  64'(m_time[k]));
            check_eq($sformatf("value_hist[%0d]", k), 64'(bus.value_hist[k]), 64'(m_val[k]));
            check_eq($sformatf("age[%0d]", k),        64'(bus.age[k]),        64'(m_age[k]));
        end
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic step(input bit ev, input logic [TW-1:0] tn, input logic signed [VW-1:0] v,
                        input bit fz, input bit fl, input bit r);
        bus.time_eq_in = ev;
        bus.time_next  = tn;
        bus.in         = v;
        bus.freeze     = fz;
        bus.flush      = fl;
        rst            = r;
        @(posedge clk_sys);
        model_edge(ev, tn, v, fz, fl, r);
        @(negedge clk_sys);
        compare_all();
    endtask

    logic [TW-1:0] tcur;

    initial begin
        model_clear();
        bus.time_eq_in = 0; bus.time_next = '0; bus.in = '0; bus.freeze = 0; bus.flush = 0;
        @(negedge clk_sys);
        step(1, 16'd50, 16'sd0, 0, 0, 1);
        step(0, 16'd0, 16'sd0, 0, 0, 1);

        // Single capture: t=100, value 5 one cycle later.
        step(1, 16'd100, 16'sd0, 0, 0, 0);
        step(0, 16'd101, 16'sd5, 0, 0, 0);
        check_eq("t1_time0", 64'(bus.time_hist[0]), 64'd100);
        check_eq("t1_val0",  64'(bus.value_hist[0]), 64'd5);
        check_eq("t1_upd",   64'(bus.hist_upd), 64'd1);

        // Ten back-to-back events overflow an 8-deep history.
        step(0, 16'd0, 16'sd0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 16'(i), (i > 1) ? 16'(10 + i - 1) : 16'sd0, 0, 0, 0);
        step(0, 16'd11, 16'sd20, 0, 0, 0);
        check_eq("t2_time0", 64'(bus.time_hist[0]), 64'd10);
        check_eq("t2_time7", 64'(bus.time_hist[7]), 64'd3);
        check_eq("t2_val0",  64'(bus.value_hist[0]), 64'd20);
        check_eq("t2_val7",  64'(bus.value_hist[7]), 64'd13);
        check_eq("t2_tv",    64'(bus.tap_valid), 64'hFF);

        // Event then freeze; frozen events ignored.
        step(1, 16'd200, 16'sd0, 0, 0, 0);
        step(1, 16'd201, 16'sd33, 1, 0, 0);
        step(1, 16'd202, 16'sd34, 1, 0, 0);
        step(0, 16'd203, 16'sd35, 0, 0, 0);

        // Flush in the pending cycle.
        step(1, 16'd300, 16'sd0, 0, 0, 0);
        step(0, 16'd301, -16'sd7, 0, 1, 0);
        step(0, 16'd302, 16'sd0, 0, 0, 0);
        check_eq("t5_fill", 64'(bus.fill_cnt), 64'd0);
        check_eq("t5_val0", 64'(bus.value_hist[0]), 64'(-16'sd7));

        // Age across timestamp wrap.
        step(0, 16'd0, 16'sd0, 0, 0, 1);
        step(1, 16'hFFF0, 16'sd0, 0, 0, 0);
        step(0, 16'hFFF8, 16'sd1, 0, 0, 0);
        step(0, 16'h0010, 16'sd0, 0, 0, 0);
        check_eq("t6_age0", 64'(bus.age[0]), 64'h0020);

        // Reset during the pending cycle discards the capture.
        step(1, 16'd5, 16'sd0, 0, 0, 0);
        step(0, 16'd6, 16'sd99, 0, 0, 1);
        check_eq("t6_rst_val0", 64'(bus.value_hist[0]), 64'd0);
        step(0, 16'd7, 16'sd98, 0, 0, 0);

        tcur = 16'hFF00;
        for (int c = 0; c < 400; c++) begin
            tcur = tcur + 16'($urandom_range(0, 40));
            step($urandom_range(0, 1) == 1, tcur, 16'($urandom),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
